mem_responder: RTL and testbench

- Main-memory responder for the cache's line refill/writeback requests; it is the memory-side end of the cache request protocol.
- Holds a word-addressed backing array, accepts one line request at a time, and inserts a fixed access latency.
- Returns read lines as beat bursts and acknowledges write lines with a single response pulse.
- Used as the memory model in cache and CPU simulation benches.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_array.sv | 28 ++
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder and its backing array.
package mem_pkg;

    // Default geometry: 8-word lines, 4096-word array, 4 idle cycles of access latency.
    localparam int LINE_WORDS_DEF = 8;
    localparam int DEPTH_DEF      = 4096;
    localparam int LATENCY_DEF    = 4;

    // Responder FSM states.
    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT,
        WR_RESP
    } state_t;

    // Bits needed to index n items, never less than one so vectors stay legal.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: combinational read, synchronous write.
module mem_array
    import mem_pkg::*;
#(
    parameter int Depth = DEPTH_DEF,
    parameter int AddrW = width_of(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [Depth];

    // Write port: one word per enabled clock edge.
    // NOTE: the storage has no reset on purpose; contents must survive rst_ni,
    // and a reset loop over every word would turn the RAM into flops.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the cache line request protocol: accepts one line
// read or write at a time, waits a fixed latency, then streams read beats
// or pulses a write response.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LineWords = LINE_WORDS_DEF,
    parameter int Depth     = DEPTH_DEF,
    parameter int Latency   = LATENCY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic        rlast_o,
    output logic        bvalid_o
);

    localparam int AddrW = width_of(Depth);
    localparam int BeatW = width_of(LineWords);
    localparam int TagW  = AddrW - BeatW;
    localparam int CntW  = width_of(Latency + 1);

    localparam logic [BeatW-1:0] LastBeat = BeatW'(LineWords - 1);
    localparam logic [CntW-1:0]  LatLoad  = CntW'(Latency);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);

    state_t           state;
    logic [TagW-1:0]  tag_q;      // line index within the array (word address minus beat bits)
    logic [BeatW-1:0] beat_q;
    logic [BeatW-1:0] next_beat;
    logic [CntW-1:0]  cnt_q;

    logic [AddrW-1:0] mem_addr;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    // Byte-offset, line-offset and above-Depth bits of the request address
    // do not select anything; high bits wrapping modulo Depth is intended.
    logic unused_addr;
    assign unused_addr = ^{req_addr_i[31:AddrW+2], req_addr_i[BeatW+1:0]};

    // Beat index wraps inside the line, so base + beat never reaches the tag.
    assign next_beat = beat_q + BeatW'(1);

    // Array write strobe: only real beat handshakes in WR_BURST reach the RAM.
    assign mem_we = wready_o & wvalid_i;

    // Array address: the word that the read data register will load next,
    // or the word currently being written.
    // NOTE: the default assignment up front keeps this block purely
    // combinational; leaving any path unassigned would infer a latch.
    always_comb begin
        mem_addr = {tag_q, beat_q};
        if (state == RD_WAIT) begin
            mem_addr = {tag_q, {BeatW{1'b0}}};
        end else if (state == RD_BURST) begin
            mem_addr = {tag_q, next_beat};
        end
    end

    mem_array #(
        .Depth (Depth),
        .AddrW (AddrW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (wdata_i),
        .rdata_o (mem_rdata)
    );

    // Request FSM with latency and beat counters; all handshake outputs are registered.
    // NOTE: every assignment here is non-blocking so each register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            tag_q       <= '0;
            beat_q      <= '0;
            cnt_q       <= '0;
            req_ready_o <= 1'b0;
            wready_o    <= 1'b0;
            rvalid_o    <= 1'b0;
            rlast_o     <= 1'b0;
            bvalid_o    <= 1'b0;
            rdata_o     <= '0;
        end else begin
            bvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        tag_q       <= req_addr_i[AddrW+1 -: TagW];
                        beat_q      <= '0;
                        cnt_q       <= LatLoad;
                        req_ready_o <= 1'b0;
                        if (req_we_i) begin
                            state    <= WR_BURST;
                            wready_o <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (cnt_q == CntOne) begin
                        state    <= RD_BURST;
                        beat_q   <= '0;
                        rvalid_o <= 1'b1;
                        rdata_o  <= mem_rdata;
                        rlast_o  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                RD_BURST: begin
                    if (rready_i) begin
                        if (beat_q == LastBeat) begin
                            state       <= IDLE;
                            rvalid_o    <= 1'b0;
                            rlast_o     <= 1'b0;
                            rdata_o     <= '0;
                            req_ready_o <= 1'b1;
                        end else begin
                            beat_q  <= next_beat;
                            rdata_o <= mem_rdata;
                            rlast_o <= (next_beat == LastBeat);
                        end
                    end
                end

                WR_BURST: begin
                    if (wvalid_i) begin
                        if (beat_q == LastBeat) begin
                            state    <= WR_WAIT;
                            wready_o <= 1'b0;
                            beat_q   <= '0;
                            cnt_q    <= LatLoad;
                        end else begin
                            beat_q <= next_beat;
                        end
                    end
                end

                WR_WAIT: begin
                    if (cnt_q == CntOne) begin
                        state    <= WR_RESP;
                        bvalid_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                WR_RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the read task queues expected beats,
// an independent monitor pops and compares every accepted read beat.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int LW  = 8;
    localparam int LAT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic [31:0] rdata_o;
    logic        rlast_o;
    logic        bvalid_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    mem_responder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .wvalid_i    (wvalid_i),
        .wready_o    (wready_o),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .rdata_o     (rdata_o),
        .rlast_o     (rlast_o),
        .bvalid_o    (bvalid_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares each accepted read beat against the scoreboard and
    // checks that data/last hold while the requester stalls.
    logic        stall_q = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_last = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("rd_stall_valid", 32'(rvalid_o), 32'd1);
                check("rd_stall_data", rdata_o, stall_data);
                check("rd_stall_last", 32'(rlast_o), 32'(stall_last));
            end
            if (rvalid_o && rready_i) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("rd_beat_data", rdata_o, e.data);
                    check("rd_beat_last", 32'(rlast_o), 32'(e.last));
                end
                stall_q <= 1'b0;
            end else if (rvalid_o) begin
                stall_q    <= 1'b1;
                stall_data <= rdata_o;
                stall_last <= rlast_o;
            end else begin
                stall_q <= 1'b0;
            end
        end
    end

    // Present a request and hold it until accepted; returns just after the handshake edge.
    task automatic issue_req(input logic we, input logic [31:0] addr);
        bit ok = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            if (req_ready_o) ok = 1'b1;
            else @(posedge clk_i);
        end
        check("req_accepted", 32'(ok), 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    // Line write of n_beats consecutive values starting at first_val.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] first_val, input int n_beats);
        issue_req(1'b1, addr);
        req_valid_i = 1'b0;
        for (int b = 0; b < n_beats; b++) begin
            bit ok = 1'b0;
            wvalid_i = 1'b1;
            wdata_i  = first_val + 32'(b);
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk_i);
                if (wready_o) ok = 1'b1;
                else @(posedge clk_i);
            end
            check("wr_beat_accepted", 32'(ok), 32'd1);
            @(posedge clk_i);
            #1;
        end
        wvalid_i = 1'b0;
    endtask

    // Write response must arrive Latency cycles after the last beat, for one cycle.
    task automatic wait_bresp;
        int cyc = 0;
        for (int i = 1; i <= 20 && cyc == 0; i++) begin
            @(posedge clk_i);
            #1;
            if (bvalid_o) cyc = i;
        end
        check("wr_resp_latency", 32'(cyc), 32'(LAT));
        @(posedge clk_i);
        #1;
        check("wr_resp_pulse", 32'(bvalid_o), 32'd0);
        check("ready_after_resp", 32'(req_ready_o), 32'd1);
    endtask

    // Line read; pat gives rready per cycle (MSB first, repeating); hold keeps req_valid_i up.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_w [LW],
                           input logic [3:0] pat, input bit hold);
        int cyc = 0;
        int busy_ready = 0;
        bit done = 1'b0;
        for (int b = 0; b < LW; b++) begin
            beat_t e;
            e.data = exp_w[b];
            e.last = (b == LW - 1);
            exp_q.push_back(e);
        end
        rready_i = 1'b1;
        issue_req(1'b0, addr);
        if (!hold) req_valid_i = 1'b0;
        for (int i = 1; i <= 20 && cyc == 0; i++) begin
            @(posedge clk_i);
            #1;
            if (req_ready_o) busy_ready++;
            if (rvalid_o) cyc = i;
        end
        check("rd_first_beat_latency", 32'(cyc), 32'(LAT));
        for (int c = 0; c < 200 && !done; c++) begin
            rready_i = pat[3 - (c % 4)];
            @(negedge clk_i);
            if (req_ready_o) busy_ready++;
            if (rvalid_o && rready_i && rlast_o) done = 1'b1;
            @(posedge clk_i);
            #1;
        end
        rready_i = 1'b0;
        check("rd_burst_done", 32'(done), 32'd1);
        check("rd_busy_ready_low", 32'(busy_ready), 32'd0);
        check("rd_ready_after_last", 32'(req_ready_o), 32'd1);
        check("rd_all_beats_seen", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] ew_a [LW];
    logic [31:0] ew_c [LW];
    logic [31:0] ew_m [LW];

    initial begin
        int b_count;
        for (int b = 0; b < LW; b++) begin
            ew_a[b] = 32'h11 + 32'(b);
            ew_c[b] = 32'hC0 + 32'(b);
            ew_m[b] = (b < 3) ? 32'hB0 + 32'(b) : 32'hA0 + 32'(b);
        end

        // Reset held 3 cycles: everything quiet, not ready.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_wready", 32'(wready_o), 32'd0);
        check("rst_bvalid", 32'(bvalid_o), 32'd0);
        check("rst_rlast", 32'(rlast_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_req_ready", 32'(req_ready_o), 32'd1);
        check("idle_rvalid", 32'(rvalid_o), 32'd0);
        check("idle_wready", 32'(wready_o), 32'd0);
        check("idle_bvalid", 32'(bvalid_o), 32'd0);

        // Line write 0x11..0x18 at 0x40, then unaligned read of the same line.
        do_write(32'h0000_0040, 32'h11, LW);
        wait_bresp();
        do_read(32'h0000_0044, ew_a, 4'b1111, 1'b0);

        // Read with rready pattern 1,0,0,1.
        do_read(32'h0000_0040, ew_a, 4'b1001, 1'b0);

        // 0x4000 wraps onto word 0 with a 4096-word array.
        do_write(32'h0000_4000, 32'hC0, LW);
        wait_bresp();
        do_read(32'h0000_0000, ew_c, 4'b1111, 1'b0);

        // req_valid_i held high: second read accepted only after the first completes.
        do_read(32'h0000_0000, ew_c, 4'b1111, 1'b1);
        do_read(32'h0000_0040, ew_a, 4'b1111, 1'b0);

        // Reset after 3 of 8 write beats: no response, partial line kept.
        do_write(32'h0000_0080, 32'hA0, LW);
        wait_bresp();
        do_write(32'h0000_0080, 32'hB0, 3);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_wready", 32'(wready_o), 32'd0);
        check("midrst_req_ready", 32'(req_ready_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        b_count = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1;
            if (bvalid_o) b_count++;
        end
        check("midrst_no_bvalid", 32'(b_count), 32'd0);
        check("midrst_ready", 32'(req_ready_o), 32'd1);
        do_read(32'h0000_0080, ew_m, 4'b1111, 1'b0);

        repeat (2) @(posedge clk_i);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
